ll_rx_stb_mrk_align: RTL and testbench
======================================

LL_RX_STB_MRK_ALIGN -- requirements
Module: ll_rx_stb_mrk_align

Interface
REQ-001 Parameter STB_BIT, default 1: strobe bit position in each 80-bit rx word.
REQ-002 Parameter MRK0_BIT, default 39: marker bit position for beat 0.
REQ-003 Parameter MRK1_BIT, default 79: marker bit position for beat 1.
REQ-004 clk_wr  in  1  single clock; all logic is on the rising edge.
REQ-005 rst_wr  in  1  reset, synchronous, active-high.
REQ-006 rx_online  in  1  enables alignment; low forces IDLE.
REQ-007 m_gen2_mode  in  1  1 = gen2 (two-beat word, checks both markers); 0 = gen1 (checks MRK0_BIT only).
REQ-008 rx_phy0  in  80  channel 0 word from the PHY.
REQ-009 rx_phy1  in  80  channel 1 word from the PHY.
REQ-010 lock_count_value  in  8  consecutive good words needed to lock; 0 is treated as 1.
REQ-011 unlock_err_value  in  4  consecutive bad words needed to drop lock; 0 is treated as 1.
REQ-012 rx_phy0_q  out  80  registered copy of rx_phy0.
REQ-013 rx_phy1_q  out  80  registered copy of rx_phy1.
REQ-014 rx_word_valid  out  1  rx_phy*_q holds a good word received while LOCKED.
REQ-015 rx_align_done  out  1  high while state is LOCKED.
REQ-016 rx_align_err  out  1  one-cycle pulse on LOCKED->SEARCH.
REQ-017 rx_align_state  out  2  FSM state: IDLE=0, SEARCH=1, LOCKED=2.
REQ-018 rx_err_cnt  out  16  saturating count of bad words seen while LOCKED.

Function
REQ-019 A word is good when all checks below pass on both channels:
- gen2: bit STB_BIT = 1, bit MRK0_BIT = 0, bit MRK1_BIT = 1.
- gen1: bit STB_BIT = 1, bit MRK0_BIT = 1; bits above 39 are ignored.
REQ-020 rx_phy0_q and rx_phy1_q are updated every cycle, with exactly one cycle of latency from rx_phy0/rx_phy1.
REQ-021 rx_word_valid is registered alongside rx_phy*_q; it is 1 only when the word was good and the state was LOCKED at sampling.
REQ-022 IDLE -> SEARCH on the first edge where rx_online = 1.
REQ-023 In SEARCH:
- A good word increments good_cnt; a bad word clears it.
- The edge that samples the Nth consecutive good word (N = effective lock_count_value) moves the state to LOCKED and clears good_cnt.
REQ-024 In LOCKED:
- A bad word increments bad_cnt and rx_err_cnt; a good word clears bad_cnt.
- The edge that samples the Mth consecutive bad word (M = effective unlock_err_value) moves the state to SEARCH, clears bad_cnt and pulses rx_align_err in the following cycle.
REQ-025 rx_online = 0 in any state moves the state to IDLE on the next edge.
- good_cnt, bad_cnt and rx_word_valid clear; rx_align_done drops.
- rx_err_cnt is retained; no rx_align_err pulse is generated.
REQ-026 If rx_online falls on the same edge as a lock or unlock event, the transition to IDLE wins.
REQ-027 good_cnt is 8 bits wide and is compared for equality with the effective value; it never wraps past 255.
REQ-028 rx_err_cnt saturates at 16'hFFFF and holds there.
REQ-029 lock_count_value and unlock_err_value are sampled each cycle; a change mid-count takes effect at the next comparison.
REQ-030 rx_align_done equals (state == LOCKED) and is a registered output.

Reset
REQ-031 While rst_wr is high at an edge:
- state = IDLE; good_cnt = bad_cnt = 0; rx_err_cnt = 0.
- rx_phy0_q = rx_phy1_q = 0.
- rx_word_valid = rx_align_done = rx_align_err = 0.
REQ-032 Reset asserted mid-operation (any state) has the same effect within one edge; rx_align_err does not pulse.

Verification
REQ-033 Gen2 lock:
- Stimulus: lock_count_value = 4; rx_online rises at cycle 0; good words from cycle 1.
- Response: state = SEARCH at cycle 1; rx_align_done = 1 from cycle 5; rx_word_valid = 1 from cycle 6.
REQ-034 Broken streak:
- Stimulus: lock_count_value = 4; good, good, good, bad (strobe = 0), then good words.
- Response: no lock until 4 consecutive good words follow the bad one.
REQ-035 Unlock:
- Stimulus: LOCKED, unlock_err_value = 2; sequence bad, good, bad, bad.
- Response: rx_err_cnt = 3; return to SEARCH after the last bad word; rx_align_err high for exactly one cycle.
REQ-036 Gen1:
- Stimulus: m_gen2_mode = 0; bit 79 = 0, bit 39 = 1, bit 1 = 1.
- Response: words are good; lock is achieved.
- Same words with m_gen2_mode = 1: never lock.
REQ-037 rx_online dropped while LOCKED, with rx_err_cnt = 7:
- Response: IDLE next cycle; rx_align_done = 0; no rx_align_err pulse; rx_err_cnt stays 7.
- Then rst_wr: rx_err_cnt = 0.
REQ-038 Saturation: force 65537 bad words while LOCKED, with unlock_err_value large and good words interleaved to hold lock -> rx_err_cnt = 16'hFFFF.

Source files
------------

// File: rtl/ll_rx_stb_mrk_align.sv
// Purpose: word-alignment tracker for a two-channel 80-bit PHY receive stream (strobe/marker checks, lock/unlock FSM).
// Latency: rx_phy*_q, rx_word_valid and status outputs are one clk_wr cycle behind the sampled inputs.
// Backpressure: none; one word pair is consumed every cycle and the stream cannot be stalled.
module ll_rx_stb_mrk_align #(
  parameter int STB_BIT  = 1,
  parameter int MRK0_BIT = 39,
  parameter int MRK1_BIT = 79
) (
  input  logic        clk_wr,
  input  logic        rst_wr,
  input  logic        rx_online,
  input  logic        m_gen2_mode,
  input  logic [79:0] rx_phy0,
  input  logic [79:0] rx_phy1,
  input  logic [7:0]  lock_count_value,
  input  logic [3:0]  unlock_err_value,
  output logic [79:0] rx_phy0_q,
  output logic [79:0] rx_phy1_q,
  output logic        rx_word_valid,
  output logic        rx_align_done,
  output logic        rx_align_err,
  output logic [1:0]  rx_align_state,
  output logic [15:0] rx_err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  good_cnt;
  logic [7:0]  good_cnt_nxt;
  logic [3:0]  bad_cnt;
  logic [3:0]  bad_cnt_nxt;
  logic        err_cnt_en;
  logic        unlock_hit;

  logic        word_good;
  logic [7:0]  lock_target;
  logic [3:0]  unlock_target;
  logic [7:0]  good_cnt_inc;
  logic [3:0]  bad_cnt_inc;

  // Per-channel framing check; gen1 only carries one beat so the upper marker is ignored.
  function automatic logic chan_ok(input logic [79:0] w, input logic gen2);
    logic ok;
    ok = w[STB_BIT];
    if (gen2) begin
      ok = ok & ~w[MRK0_BIT] & w[MRK1_BIT];
    end else begin
      ok = ok & w[MRK0_BIT];
    end
    return ok;
  endfunction

  assign word_good = chan_ok(rx_phy0, m_gen2_mode) & chan_ok(rx_phy1, m_gen2_mode);

  // A programmed threshold of zero behaves like one.
  assign lock_target   = (lock_count_value == 8'd0) ? 8'd1 : lock_count_value;
  assign unlock_target = (unlock_err_value == 4'd0) ? 4'd1 : unlock_err_value;

  // Counters saturate instead of wrapping so a stale streak can never alias a small threshold.
  assign good_cnt_inc = (good_cnt == 8'hFF) ? 8'hFF : good_cnt + 8'd1;
  assign bad_cnt_inc  = (bad_cnt == 4'hF) ? 4'hF : bad_cnt + 4'd1;

  // Next-state and counter update; dropping rx_online overrides any lock/unlock decision.
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    bad_cnt_nxt  = bad_cnt;
    err_cnt_en   = 1'b0;
    unlock_hit   = 1'b0;
    if (!rx_online) begin
      state_nxt    = ST_IDLE;
      good_cnt_nxt = 8'd0;
      bad_cnt_nxt  = 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (word_good) begin
            // Equality test: the lock fires on exactly the Nth consecutive good word.
            if (good_cnt_inc == lock_target) begin
              state_nxt    = ST_LOCKED;
              good_cnt_nxt = 8'd0;
            end else begin
              good_cnt_nxt = good_cnt_inc;
            end
          end else begin
            good_cnt_nxt = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (word_good) begin
            bad_cnt_nxt = 4'd0;
          end else begin
            err_cnt_en = 1'b1;
            // >= so that lowering the threshold mid-streak still drops lock promptly.
            if (bad_cnt_inc >= unlock_target) begin
              state_nxt   = ST_SEARCH;
              bad_cnt_nxt = 4'd0;
              unlock_hit  = 1'b1;
            end else begin
              bad_cnt_nxt = bad_cnt_inc;
            end
          end
        end
        default: begin
          state_nxt    = ST_IDLE;
          good_cnt_nxt = 8'd0;
          bad_cnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  // FSM state and streak counters.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state    <= ST_IDLE;
      good_cnt <= 8'd0;
      bad_cnt  <= 4'd0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
      bad_cnt  <= bad_cnt_nxt;
    end
  end

  // Lifetime error counter: survives rx_online drops, cleared only by reset, sticks at all-ones.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      rx_err_cnt <= 16'd0;
    end else if (err_cnt_en && (rx_err_cnt != 16'hFFFF)) begin
      rx_err_cnt <= rx_err_cnt + 16'd1;
    end
  end

  // Data pipeline stage with its qualifier, plus registered lock status and unlock pulse.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      rx_phy0_q     <= 80'd0;
      rx_phy1_q     <= 80'd0;
      rx_word_valid <= 1'b0;
      rx_align_done <= 1'b0;
      rx_align_err  <= 1'b0;
    end else begin
      rx_phy0_q     <= rx_phy0;
      rx_phy1_q     <= rx_phy1;
      rx_word_valid <= rx_online & word_good & (state == ST_LOCKED);
      rx_align_done <= (state_nxt == ST_LOCKED);
      rx_align_err  <= unlock_hit;
    end
  end

  assign rx_align_state = state;

endmodule

// File: tb/tb_ll_rx_stb_mrk_align.sv
// Purpose: randomized + directed bench for ll_rx_stb_mrk_align against a streak-counting reference model.
// Latency: the model is advanced at each rising edge; outputs are compared 1 ns later.
// Backpressure: not applicable; one word pair is driven every cycle.
module tb_ll_rx_stb_mrk_align;

  logic        clk_wr = 1'b0;
  logic        rst_wr;
  logic        rx_online;
  logic        m_gen2_mode;
  logic [79:0] rx_phy0;
  logic [79:0] rx_phy1;
  logic [7:0]  lock_count_value;
  logic [3:0]  unlock_err_value;
  logic [79:0] rx_phy0_q;
  logic [79:0] rx_phy1_q;
  logic        rx_word_valid;
  logic        rx_align_done;
  logic        rx_align_err;
  logic [1:0]  rx_align_state;
  logic [15:0] rx_err_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (plain integers, streak lengths rather than hardware counters).
  int          m_st;
  int          m_streak_good;
  int          m_streak_bad;
  int          m_errs;
  logic [79:0] m_q0;
  logic [79:0] m_q1;
  bit          m_valid;
  bit          m_done;
  bit          m_aerr;

  ll_rx_stb_mrk_align dut (
    .clk_wr           (clk_wr),
    .rst_wr           (rst_wr),
    .rx_online        (rx_online),
    .m_gen2_mode      (m_gen2_mode),
    .rx_phy0          (rx_phy0),
    .rx_phy1          (rx_phy1),
    .lock_count_value (lock_count_value),
    .unlock_err_value (unlock_err_value),
    .rx_phy0_q        (rx_phy0_q),
    .rx_phy1_q        (rx_phy1_q),
    .rx_word_valid    (rx_word_valid),
    .rx_align_done    (rx_align_done),
    .rx_align_err     (rx_align_err),
    .rx_align_state   (rx_align_state),
    .rx_err_cnt       (rx_err_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word framing rule written as bit-pattern comparisons.
  function automatic bit tb_good(input logic [79:0] w, input bit gen2);
    if (gen2) return ({w[79], w[39], w[1]} == 3'b101);
    return ({w[39], w[1]} == 2'b11);
  endfunction

  // Random payload with framing bits forced good, optionally corrupting one framing bit.
  function automatic logic [79:0] mk_word(input bit gen2, input bit good);
    logic [79:0] w;
    int          sel;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[79:64] = 16'($urandom);
    w[1] = 1'b1;
    if (gen2) begin
      w[39] = 1'b0;
      w[79] = 1'b1;
    end else begin
      w[39] = 1'b1;
    end
    if (!good) begin
      sel = int'($urandom_range(gen2 ? 2 : 1, 0));
      case (sel)
        0:       w[1]  = 1'b0;
        1:       w[39] = ~w[39];
        default: w[79] = 1'b0;
      endcase
    end
    return w;
  endfunction

  // Drive a word pair; a bad pair has a defect on one randomly chosen channel.
  task automatic drive_pair(input bit good);
    rx_phy0 = mk_word(m_gen2_mode, 1'b1);
    rx_phy1 = mk_word(m_gen2_mode, 1'b1);
    if (!good) begin
      if ($urandom_range(1, 0) == 1) rx_phy0 = mk_word(m_gen2_mode, 1'b0);
      else                           rx_phy1 = mk_word(m_gen2_mode, 1'b0);
    end
  endtask

  // Apply the rules to the inputs present at this edge.
  function automatic void model_edge();
    bit g;
    int n_lock;
    int n_unlock;
    n_lock   = (lock_count_value == 0) ? 1 : int'(lock_count_value);
    n_unlock = (unlock_err_value == 0) ? 1 : int'(unlock_err_value);
    if (rst_wr) begin
      m_st = 0; m_streak_good = 0; m_streak_bad = 0; m_errs = 0;
      m_q0 = '0; m_q1 = '0; m_valid = 0; m_done = 0; m_aerr = 0;
      return;
    end
    g = tb_good(rx_phy0, m_gen2_mode) && tb_good(rx_phy1, m_gen2_mode);
    m_q0    = rx_phy0;
    m_q1    = rx_phy1;
    m_valid = rx_online && g && (m_st == 2);
    m_aerr  = 0;
    if (!rx_online) begin
      m_st = 0; m_streak_good = 0; m_streak_bad = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (g) begin
        m_streak_good = (m_streak_good >= 255) ? 255 : m_streak_good + 1;
        if (m_streak_good == n_lock) begin
          m_st = 2; m_streak_good = 0;
        end
      end else begin
        m_streak_good = 0;
      end
    end else begin
      if (g) begin
        m_streak_bad = 0;
      end else begin
        m_streak_bad++;
        if (m_errs < 65535) m_errs++;
        if (m_streak_bad >= n_unlock) begin
          m_st = 1; m_streak_bad = 0; m_aerr = 1;
        end
      end
    end
    m_done = (m_st == 2);
  endfunction

  // One clock: advance the model at the edge, compare every output just after it.
  task automatic step();
    @(posedge clk_wr);
    model_edge();
    #1;
    chk("state", 80'(rx_align_state), 80'(m_st));
    chk("done",  80'(rx_align_done),  80'(m_done));
    chk("aerr",  80'(rx_align_err),   80'(m_aerr));
    chk("valid", 80'(rx_word_valid),  80'(m_valid));
    chk("errcnt", 80'(rx_err_cnt),    80'(m_errs));
    chk("phy0_q", rx_phy0_q, m_q0);
    chk("phy1_q", rx_phy1_q, m_q1);
  endtask

  initial begin
    rst_wr = 1'b1; rx_online = 1'b0; m_gen2_mode = 1'b1;
    lock_count_value = 8'd4; unlock_err_value = 4'd2;
    rx_phy0 = '0; rx_phy1 = '0;
    step();
    step();
    chk("rst_state", 80'(rx_align_state), 80'(0));
    chk("rst_q0", rx_phy0_q, 80'd0);
    rst_wr = 1'b0;
    drive_pair(1'b1);
    step();
    step();
    chk("idle_hold", 80'(rx_align_state), 80'(0));

    // Gen2 lock: online rises at cycle 0, good words from cycle 1.
    rx_online = 1'b1;
    drive_pair(1'b0);
    step();
    chk("lock_search_c1", 80'(rx_align_state), 80'(1));
    for (int i = 1; i <= 4; i++) begin
      drive_pair(1'b1);
      step();
      chk("lock_done_ramp", 80'(rx_align_done), 80'(i == 4));
    end
    chk("lock_valid_c5", 80'(rx_word_valid), 80'(0));
    drive_pair(1'b1);
    step();
    chk("lock_valid_c6", 80'(rx_word_valid), 80'(1));

    // Unlock: bad, good, bad, bad with threshold 2.
    unlock_err_value = 4'd2;
    drive_pair(1'b0); step();
    drive_pair(1'b1); step();
    drive_pair(1'b0); step();
    chk("unl_still_locked", 80'(rx_align_state), 80'(2));
    drive_pair(1'b0); step();
    chk("unl_errcnt", 80'(rx_err_cnt), 80'(3));
    chk("unl_state", 80'(rx_align_state), 80'(1));
    chk("unl_pulse", 80'(rx_align_err), 80'(1));
    drive_pair(1'b1); step();
    chk("unl_pulse_end", 80'(rx_align_err), 80'(0));

    // Broken streak: good x3 (one already seen), bad, then four good needed.
    drive_pair(1'b1); step();
    drive_pair(1'b1); step();
    rx_phy0 = mk_word(1'b1, 1'b1); rx_phy0[1] = 1'b0;
    rx_phy1 = mk_word(1'b1, 1'b1); rx_phy1[1] = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      drive_pair(1'b1);
      step();
      chk("brk_done", 80'(rx_align_done), 80'(i == 4));
    end

    // Bring error count to 7 while holding lock, then take the link offline.
    unlock_err_value = 4'd15;
    for (int i = 0; i < 4; i++) begin
      drive_pair(1'b0); step();
      drive_pair(1'b1); step();
    end
    chk("off_err7", 80'(rx_err_cnt), 80'(7));
    rx_online = 1'b0;
    step();
    chk("off_state", 80'(rx_align_state), 80'(0));
    chk("off_done", 80'(rx_align_done), 80'(0));
    chk("off_nopulse", 80'(rx_align_err), 80'(0));
    chk("off_keep7", 80'(rx_err_cnt), 80'(7));
    step();
    chk("off_nopulse2", 80'(rx_align_err), 80'(0));
    rst_wr = 1'b1;
    step();
    chk("off_rst_err", 80'(rx_err_cnt), 80'(0));
    rst_wr = 1'b0;

    // Gen1 words (bit79 = 0) lock in gen1 mode but never in gen2 mode.
    m_gen2_mode = 1'b0; lock_count_value = 8'd3; rx_online = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_phy0 = mk_word(1'b0, 1'b1); rx_phy0[79] = 1'b0;
      rx_phy1 = mk_word(1'b0, 1'b1); rx_phy1[79] = 1'b0;
      step();
    end
    chk("g1_lock", 80'(rx_align_state), 80'(2));
    rx_online = 1'b0;
    step();
    m_gen2_mode = 1'b1; rx_online = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_phy0 = mk_word(1'b0, 1'b1); rx_phy0[79] = 1'b0;
      rx_phy1 = mk_word(1'b0, 1'b1); rx_phy1[79] = 1'b0;
      step();
    end
    chk("g1_in_g2_nolock", 80'(rx_align_done), 80'(0));
    chk("g1_in_g2_search", 80'(rx_align_state), 80'(1));

    // Randomized traffic with threshold changes, mode flips, offline windows and resets.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(999, 0));
      rst_wr = (r < 3);
      if (r >= 3 && r < 23) rx_online = ~rx_online;
      else if (!rx_online && r < 300) rx_online = 1'b1;
      if ($urandom_range(99, 0) == 0) lock_count_value = 8'($urandom_range(6, 0));
      if ($urandom_range(99, 0) == 0) unlock_err_value = 4'($urandom_range(4, 0));
      if ($urandom_range(199, 0) == 0) m_gen2_mode = ~m_gen2_mode;
      drive_pair($urandom_range(99, 0) >= 15);
      step();
    end
    rst_wr = 1'b0;

    // Saturation: 14 bad + 1 good per group keeps lock while the error counter climbs.
    rst_wr = 1'b1; step(); rst_wr = 1'b0;
    m_gen2_mode = 1'b1; rx_online = 1'b1;
    lock_count_value = 8'd1; unlock_err_value = 4'd15;
    drive_pair(1'b1); step(); step();
    chk("sat_locked", 80'(rx_align_state), 80'(2));
    for (int g = 0; g < 4682; g++) begin
      for (int b = 0; b < 14; b++) begin
        drive_pair(1'b0);
        step();
      end
      drive_pair(1'b1);
      step();
    end
    chk("sat_ffff", 80'(rx_err_cnt), 80'(16'hFFFF));
    chk("sat_still_locked", 80'(rx_align_done), 80'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
